// File: rtl/flag_pkg.sv
// Shared flag-register and branch-condition definitions.
// Used by flag_branch_unit and branch_cond_eval.
package flag_pkg;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    localparam logic [2:0] COND_NE  = 3'b000;
    localparam logic [2:0] COND_EQ  = 3'b001;
    localparam logic [2:0] COND_GT  = 3'b010;
    localparam logic [2:0] COND_LT  = 3'b011;
    localparam logic [2:0] COND_GTE = 3'b100;
    localparam logic [2:0] COND_LTE = 3'b101;
    localparam logic [2:0] COND_OVF = 3'b110;
    localparam logic [2:0] COND_UNC = 3'b111;

    localparam logic [2:0] EN_ALL  = 3'b111;
    localparam logic [2:0] EN_Z    = 3'b010;
    localparam logic [2:0] EN_NONE = 3'b000;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of a 3-bit branch condition
// against an {N,Z,V} flag vector.
module branch_cond_eval
    import flag_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [2:0] cond,
    output logic       taken
);

    logic n;
    logic z;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];

    // Condition table decode
    always_comb begin
        taken = 1'b0;
        unique case (cond)
            COND_NE:  taken = ~z;
            COND_EQ:  taken = z;
            COND_GT:  taken = ~z & ~n;
            COND_LT:  taken = n;
            COND_GTE: taken = z | (~z & ~n);
            COND_LTE: taken = n | z;
            COND_OVF: taken = v;
            COND_UNC: taken = 1'b1;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register and branch resolution stage behind the ALU.
// Define FLAG_BRANCH_STATS_EN to build the taken/not-taken counters.
module flag_branch_unit
    import flag_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [2:0]       alu_flags,
    input  logic [2:0]       alu_flag_en,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    output logic [2:0]       flags_q,
    output logic             br_valid_q,
    output logic             br_taken_q,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] ntaken_cnt
);

    logic       upd;
    logic       res;
    logic [2:0] byp_mask;
    logic [2:0] eff_flags;
    logic       cond_true;

    assign upd = ex_valid & ~stall & ~flush;
    assign res = br_valid & ~stall & ~flush;

    // Same-cycle ALU writes are visible to the branch even under stall.
    assign byp_mask  = {3{ex_valid & ~flush}} & alu_flag_en;
    assign eff_flags = BYPASS
                     ? ((alu_flags & byp_mask) | (flags_q & ~byp_mask))
                     : flags_q;

    branch_cond_eval u_eval (
        .flags (eff_flags),
        .cond  (br_cond),
        .taken (cond_true)
    );

    // Flag register: per-bit masked write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else if (upd) begin
            flags_q <= (alu_flags & alu_flag_en) | (flags_q & ~alu_flag_en);
        end
    end

    // Registered branch decision, single-cycle pulse per resolution
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_valid_q <= 1'b0;
            br_taken_q <= 1'b0;
        end else if (!stall) begin
            br_valid_q <= res;
            br_taken_q <= res & cond_true;
        end
    end

`ifdef FLAG_BRANCH_STATS_EN
    // Saturating resolution counters, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_cnt  <= '0;
            ntaken_cnt <= '0;
        end else if (res) begin
            if (cond_true && taken_cnt != '1) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
            if (!cond_true && ntaken_cnt != '1) begin
                ntaken_cnt <= ntaken_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign taken_cnt  = '0;
    assign ntaken_cnt = '0;
`endif

endmodule

// File: tb/tb_flag_branch_unit.sv
// Randomized self-checking bench for flag_branch_unit.
// Runs a BYPASS=1 and a BYPASS=0 instance side by side.
module tb_flag_branch_unit;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    logic stall;
    logic flush;
    logic ex_valid;
    logic [2:0] alu_flags;
    logic [2:0] alu_flag_en;
    logic br_valid;
    logic [2:0] br_cond;

    logic [2:0] fq0, fq1;
    logic bv0, bv1, bt0, bt1;
    logic [CW-1:0] tc0, tc1, nc0, nc1;

    int total = 0;
    int bad = 0;

    logic [2:0] m_f [2];
    logic m_bv [2];
    logic m_bt [2];
    logic [CW-1:0] m_tc [2];
    logic [CW-1:0] m_nc [2];

    always #5 clk = ~clk;

    flag_branch_unit #(.CNT_W(CW), .BYPASS(1'b1)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .alu_flags(alu_flags),
        .alu_flag_en(alu_flag_en), .br_valid(br_valid),
        .br_cond(br_cond), .flags_q(fq0), .br_valid_q(bv0),
        .br_taken_q(bt0), .taken_cnt(tc0), .ntaken_cnt(nc0)
    );

    flag_branch_unit #(.CNT_W(CW), .BYPASS(1'b0)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .alu_flags(alu_flags),
        .alu_flag_en(alu_flag_en), .br_valid(br_valid),
        .br_cond(br_cond), .flags_q(fq1), .br_valid_q(bv1),
        .br_taken_q(bt1), .taken_cnt(tc1), .ntaken_cnt(nc1)
    );

    function automatic logic cond_ok(input logic [2:0] f, input logic [2:0] c);
        logic n, z, v;
        n = f[2];
        z = f[1];
        v = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [12:0] get_obs(input int b);
        if (b == 0) return {fq0, bv0, bt0, tc0, nc0};
        return {fq1, bv1, bt1, tc1, nc1};
    endfunction

    function automatic logic [12:0] get_exp(input int b);
        return {m_f[b], m_bv[b], m_bt[b], m_tc[b], m_nc[b]};
    endfunction

    task automatic mreset();
        for (int b = 0; b < 2; b++) begin
            m_f[b] = '0;
            m_bv[b] = 1'b0;
            m_bt[b] = 1'b0;
            m_tc[b] = '0;
            m_nc[b] = '0;
        end
    endtask

    task automatic idle();
        stall = 0;
        flush = 0;
        ex_valid = 0;
        alu_flags = 0;
        alu_flag_en = 0;
        br_valid = 0;
        br_cond = 0;
    endtask

    // Advance the model by one clock, then the DUT; sample at edge+1
    task automatic step();
        logic [2:0] eff;
        logic ok, res;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 3; i++) begin
                if (b == 0 && ex_valid && !flush && alu_flag_en[i])
                    eff[i] = alu_flags[i];
                else
                    eff[i] = m_f[b][i];
            end
            ok = cond_ok(eff, br_cond);
            res = br_valid && !stall && !flush;
            if (ex_valid && !stall && !flush) begin
                for (int i = 0; i < 3; i++)
                    if (alu_flag_en[i]) m_f[b][i] = alu_flags[i];
            end
            if (!stall) begin
                m_bv[b] = res;
                m_bt[b] = res && ok;
            end
`ifdef FLAG_BRANCH_STATS_EN
            if (res && ok && m_tc[b] != 4'hF) m_tc[b] = m_tc[b] + 1;
            if (res && !ok && m_nc[b] != 4'hF) m_nc[b] = m_nc[b] + 1;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        mreset();
        @(posedge clk);
        #1;
        total++;
        if (get_obs(0) !== 13'd0) begin
            bad++;
            $display("FAIL reset_byp: got %h want 0", get_obs(0));
        end
        total++;
        if (get_obs(1) !== 13'd0) begin
            bad++;
            $display("FAIL reset_nobyp: got %h want 0", get_obs(1));
        end
        rst = 0;
    endtask

    task automatic test_masking();
        idle();
        ex_valid = 1;
        alu_flags = 3'b101;
        alu_flag_en = 3'b111;
        step();
        alu_flags = 3'b000;
        alu_flag_en = 3'b010;
        step();
        total++;
        if (fq0 !== 3'b101 || fq1 !== 3'b101) begin
            bad++;
            $display("FAIL mask_z0: got %b/%b want 101", fq0, fq1);
        end
        alu_flags = 3'b010;
        step();
        total++;
        if (fq0 !== 3'b111 || fq1 !== 3'b111) begin
            bad++;
            $display("FAIL mask_z1: got %b/%b want 111", fq0, fq1);
        end
        total++;
        if (get_obs(0) !== get_exp(0)) begin
            bad++;
            $display("FAIL mask_model: got %h want %h", get_obs(0), get_exp(0));
        end
    endtask

    task automatic test_bypass();
        idle();
        ex_valid = 1;
        alu_flags = 3'b010;
        alu_flag_en = 3'b111;
        step();
        alu_flags = 3'b000;
        br_valid = 1;
        br_cond = 3'b001;
        step();
        total++;
        if (bv0 !== 1'b1 || bt0 !== 1'b0) begin
            bad++;
            $display("FAIL bypass_on: got v%b t%b want v1 t0", bv0, bt0);
        end
        total++;
        if (bv1 !== 1'b1 || bt1 !== 1'b1) begin
            bad++;
            $display("FAIL bypass_off: got v%b t%b want v1 t1", bv1, bt1);
        end
    endtask

    task automatic test_conditions();
        logic [2:0] fl [4];
        fl[0] = 3'b000;
        fl[1] = 3'b010;
        fl[2] = 3'b100;
        fl[3] = 3'b001;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 8; c++) begin
                idle();
                ex_valid = 1;
                alu_flags = fl[k];
                alu_flag_en = 3'b111;
                step();
                idle();
                br_valid = 1;
                br_cond = 3'(c);
                step();
                for (int b = 0; b < 2; b++) begin
                    total++;
                    if (get_obs(b) !== get_exp(b)) begin
                        bad++;
                        $display("FAIL cond f=%b c=%0d inst%0d: got %h want %h",
                                 fl[k], c, b, get_obs(b), get_exp(b));
                    end
                end
            end
        end
        total++;
        if (bt0 !== 1'b1) begin
            bad++;
            $display("FAIL cond_unc: got %b want 1", bt0);
        end
    endtask

    task automatic test_stall_flush();
        logic [12:0] prev0, prev1;
        idle();
        br_valid = 1;
        br_cond = 3'b111;
        step();
        prev0 = get_obs(0);
        prev1 = get_obs(1);
        stall = 1;
        ex_valid = 1;
        alu_flags = ~fq0;
        alu_flag_en = 3'b111;
        br_cond = 3'b001;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (get_obs(0) !== prev0 || get_obs(1) !== prev1) begin
                bad++;
                $display("FAIL stall_hold%0d: got %h/%h want %h/%h",
                         i, get_obs(0), get_obs(1), prev0, prev1);
            end
        end
        stall = 0;
        flush = 1;
        prev0 = get_obs(0);
        step();
        total++;
        if (fq0 !== prev0[12:10] || bv0 !== 1'b0 || bt0 !== 1'b0) begin
            bad++;
            $display("FAIL flush: got f%b v%b t%b want f%b v0 t0",
                     fq0, bv0, bt0, prev0[12:10]);
        end
        br_cond = 3'b111;
        flush = 0;
        step();
        prev0 = get_obs(0);
        prev1 = get_obs(1);
        stall = 1;
        flush = 1;
        step();
        total++;
        if (get_obs(0) !== prev0 || get_obs(1) !== prev1) begin
            bad++;
            $display("FAIL stall_flush: got %h/%h want %h/%h",
                     get_obs(0), get_obs(1), prev0, prev1);
        end
        total++;
        if (get_obs(0) !== get_exp(0) || get_obs(1) !== get_exp(1)) begin
            bad++;
            $display("FAIL sf_model: got %h/%h want %h/%h",
                     get_obs(0), get_obs(1), get_exp(0), get_exp(1));
        end
    endtask

    task automatic test_reset_mid();
        idle();
        ex_valid = 1;
        alu_flags = 3'b111;
        alu_flag_en = 3'b111;
        br_valid = 1;
        br_cond = 3'b111;
        step();
        total++;
        if (fq0 !== 3'b111 || bv0 !== 1'b1) begin
            bad++;
            $display("FAIL pre_rst: got f%b v%b want f111 v1", fq0, bv0);
        end
        #3;
        rst = 1;
        mreset();
        #1;
        total++;
        if (get_obs(0) !== 13'd0 || get_obs(1) !== 13'd0) begin
            bad++;
            $display("FAIL rst_async: got %h/%h want 0", get_obs(0), get_obs(1));
        end
        idle();
        #2;
        rst = 0;
        br_valid = 1;
        br_cond = 3'b001;
        step();
        total++;
        if (bv0 !== 1'b1 || bt0 !== 1'b0 || bt1 !== 1'b0) begin
            bad++;
            $display("FAIL post_rst_eq: got v%b t%b/%b want v1 t0/0", bv0, bt0, bt1);
        end
        br_cond = 3'b000;
        step();
        total++;
        if (bt0 !== 1'b1 || bt1 !== 1'b1) begin
            bad++;
            $display("FAIL post_rst_ne: got %b/%b want 1/1", bt0, bt1);
        end
    endtask

    task automatic test_random();
        logic [2:0] masks [4];
        masks[0] = 3'b111;
        masks[1] = 3'b010;
        masks[2] = 3'b000;
        for (int n = 0; n < 400; n++) begin
            masks[3] = 3'($urandom);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 5) == 0);
            ex_valid = 1'($urandom);
            alu_flags = 3'($urandom);
            alu_flag_en = masks[$urandom_range(0, 3)];
            br_valid = ($urandom_range(0, 2) != 0);
            br_cond = 3'($urandom);
            step();
            for (int b = 0; b < 2; b++) begin
                total++;
                if (get_obs(b) !== get_exp(b)) begin
                    bad++;
                    $display("FAIL random n=%0d inst%0d: got %h want %h",
                             n, b, get_obs(b), get_exp(b));
                end
            end
        end
    endtask

    task automatic test_stats();
        logic [CW-1:0] exp_t;
        idle();
        rst = 1;
        mreset();
        #2;
        rst = 0;
        br_valid = 1;
        br_cond = 3'b111;
        for (int i = 0; i < 17; i++) step();
`ifdef FLAG_BRANCH_STATS_EN
        exp_t = 4'hF;
`else
        exp_t = 4'h0;
`endif
        total++;
        if (tc0 !== exp_t || tc1 !== exp_t) begin
            bad++;
            $display("FAIL stats_taken: got %0d/%0d want %0d", tc0, tc1, exp_t);
        end
        total++;
        if (nc0 !== 4'h0 || nc1 !== 4'h0) begin
            bad++;
            $display("FAIL stats_ntaken: got %0d/%0d want 0", nc0, nc1);
        end
        br_cond = 3'b001;
        for (int i = 0; i < 3; i++) step();
        total++;
        if (get_obs(0) !== get_exp(0) || get_obs(1) !== get_exp(1)) begin
            bad++;
            $display("FAIL stats_model: got %h/%h want %h/%h",
                     get_obs(0), get_obs(1), get_exp(0), get_exp(1));
        end
    endtask

    initial begin
        idle();
        rst = 1;
        mreset();
        test_reset();
        test_masking();
        test_bypass();
        test_conditions();
        test_stall_flush();
        test_reset_mid();
        test_random();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Sequential flag-register and branch-resolution stage sitting directly downstream of the 16-bit ALU. It latches the ALU's N/Z/V flags under the ALU's per-flag enable mask. It evaluates the 3-bit branch condition of the instruction in decode against the architecturally correct flags, bypassing same-cycle ALU updates. It also produces a registered taken/not-taken decision for the fetch stage.

## Interface
- CNT_W, 16, width of each branch statistics counter (used only when stats are compiled in)
- BYPASS, 1, 1 = branch evaluation sees the ALU flags being written this cycle; 0 = branch sees only the stored flags

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  pipeline hold; freezes all state
- flush  in  1  squashes this cycle's ALU flag update and branch
- ex_valid  in  1  ALU result in execute is a real instruction
- alu_flags  in  3  {N,Z,V} from ALU, bit2=N, bit1=Z, bit0=V
- alu_flag_en  in  3  per-flag write enable from ALU, same bit order (111 for ADD/SUB, 010 for XOR/RED/shifts/PADDSB, 000 otherwise)
- br_valid  in  1  branch instruction present in decode
- br_cond  in  3  condition code
- flags_q  out  3  stored {N,Z,V}
- br_valid_q  out  1  registered: a branch was resolved last cycle
- br_taken_q  out  1  registered taken decision, meaningful only with br_valid_q
- taken_cnt  out  CNT_W  resolved-taken count
- ntaken_cnt  out  CNT_W  resolved-not-taken count

## Operation
- upd = ex_valid & ~stall & ~flush. On upd, each flags_q[i] loads alu_flags[i] where alu_flag_en[i]=1; bits with en=0 hold.
- eff_flags = BYPASS ? (bits with ex_valid & ~flush & alu_flag_en[i] replaced by alu_flags[i], others flags_q) : flags_q. Stall does not gate the bypass.
- Condition evaluation on eff_flags (N,Z,V):
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z & ~N
  - 011 LT: N
  - 100 GTE: Z | (~Z & ~N)
  - 101 LTE: N | Z
  - 110 OVF: V
  - 111 UNCOND: 1
- res = br_valid & ~stall & ~flush. Next cycle: br_valid_q = res; br_taken_q = res ? cond_true : 0.
- Stall: flags_q, br_valid_q, br_taken_q and counters all hold their values.
- Flush without stall: flags hold; br_valid_q and br_taken_q clear to 0.
- Stall and flush together: stall wins, and all state holds.
- Unknown alu_flag_en patterns are applied bitwise, with no decoding.

## Timing
- Reset: flags_q=000, br_valid_q=0, br_taken_q=0, taken_cnt=0, ntaken_cnt=0. Reset is asynchronous in effect. Reset asserted mid-operation discards any in-flight resolution.
- Flag write latency: 1 cycle (ALU flags in cycle t are visible on flags_q in t+1).
- Branch resolution latency: 1 cycle from br_valid sampled to br_valid_q/br_taken_q.
- With BYPASS=1, an ALU op in EX and a dependent branch in ID in the same cycle need no stall. With BYPASS=0, the hazard unit must insert one stall.
- br_valid_q is a single-cycle pulse per resolved branch. Back-to-back branches give consecutive pulses.

## Configuration
- FLAG_BRANCH_STATS_EN defined:
  - taken_cnt increments on res & cond_true.
  - ntaken_cnt increments on res & ~cond_true.
  - Both counters saturate at all-ones; there is no wrap.
  - Both counters are cleared only by rst.
- FLAG_BRANCH_STATS_EN undefined: the counter logic is removed, and taken_cnt and ntaken_cnt are driven constant 0. The port list is unchanged.

## Structure
- Shared package flag_pkg:
  - flag bit indices FLAG_N=2, FLAG_Z=1, FLAG_V=0
  - condition-code constants COND_NE through COND_UNC (000–111)
  - enable masks EN_ALL=111, EN_Z=010, EN_NONE=000
- One combinational sub-module, branch_cond_eval: inputs flags[2:0] and cond[2:0], output taken. It is reused by any future early-branch logic.

## Test plan
- Flag masking: flags_q=101; ex_valid=1, alu_flags=000, alu_flag_en=010 -> next flags_q=101 (only Z written, stays 0). Then alu_flags=010, en=010 -> flags_q=111.
- Bypass: flags_q=010; in the same cycle, ADD with alu_flags=000, en=111, and br_valid=1, br_cond=001 (EQ) -> next cycle br_valid_q=1, br_taken_q=0. Repeat with BYPASS=0 -> br_taken_q=1.
- All conditions: sweep flags {000,010,100,001} × cond 000–111 with no ALU update -> br_taken_q matches the condition table. UNCOND is always 1, and OVF=1 only when V=1.
- Stall/flush: branch with stall=1 for 3 cycles -> outputs hold. Flush=1 with ex_valid and br_valid -> flags unchanged, br_valid_q=0. Stall and flush together -> all state holds.
- Reset mid-operation: assert rst between clock edges after flags_q=111, br_valid_q=1 -> all outputs 0 immediately. First branch after release sees flags 000.
- Stats (with FLAG_BRANCH_STATS_EN, CNT_W=4): 17 taken branches -> taken_cnt=15 (saturated), ntaken_cnt=0. Without the macro, both counters read 0 throughout.
